// File: rtl/fpu_issue_ctrl.sv
// FP issue/writeback sequencer: decodes OPFP/LOADFP, tracks pending destinations
// in a scoreboard and books the single register-file write port in a slot shift register.
module fpu_issue_ctrl #(
    parameter int ADD_LAT  = 3,
    parameter int MUL_LAT  = 4,
    parameter int LOAD_LAT = 2,
    parameter int MAX_LAT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [6:0] opcode,
    input  logic [4:0] funct5,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       stall,
    output logic       issue_add,
    output logic       issue_sub,
    output logic       issue_mul,
    output logic       issue_load,
    output logic       illegal,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic [1:0] wb_sel,
    output logic       busy
);

    localparam logic [6:0] OPC_OPFP   = 7'b1010011;
    localparam logic [6:0] OPC_LOADFP = 7'b0000111;
    localparam logic [4:0] F5_ADD     = 5'b00000;
    localparam logic [4:0] F5_SUB     = 5'b00001;
    localparam logic [4:0] F5_MUL     = 5'b00010;
    localparam logic [1:0] SEL_ADD    = 2'b00;
    localparam logic [1:0] SEL_MUL    = 2'b01;
    localparam logic [1:0] SEL_LOAD   = 2'b10;

    generate
        if (ADD_LAT < 1 || MUL_LAT < 1 || LOAD_LAT < 1) begin : g_lat_min_check
            $error("fpu_issue_ctrl: every unit latency must be at least 1");
        end
        if (MAX_LAT < ADD_LAT || MAX_LAT < MUL_LAT || MAX_LAT < LOAD_LAT) begin : g_lat_max_check
            $error("fpu_issue_ctrl: MAX_LAT must cover every unit latency");
        end
    endgenerate

    logic        res_v   [1:MAX_LAT];
    logic [4:0]  res_rd  [1:MAX_LAT];
    logic [1:0]  res_sel [1:MAX_LAT];
    logic        nxt_v   [1:MAX_LAT];
    logic [4:0]  nxt_rd  [1:MAX_LAT];
    logic [1:0]  nxt_sel [1:MAX_LAT];
    logic [31:0] sb;
    logic [31:0] sb_nxt;

    logic       is_opfp;
    logic       is_load;
    logic       op_add;
    logic       op_sub;
    logic       op_mul;
    logic       supported;
    logic       uses_rs;
    logic       hazard;
    logic       slot_conflict;
    logic       accept;
    logic [1:0] op_sel;
    int         op_lat;

    // Decode and hazard detection
    always_comb begin
        is_opfp   = (opcode == OPC_OPFP);
        is_load   = (opcode == OPC_LOADFP);
        op_add    = is_opfp && (funct5 == F5_ADD);
        op_sub    = is_opfp && (funct5 == F5_SUB);
        op_mul    = is_opfp && (funct5 == F5_MUL);
        supported = op_add || op_sub || op_mul || is_load;
        uses_rs   = op_add || op_sub || op_mul;

        op_lat = ADD_LAT;
        op_sel = SEL_ADD;
        if (op_mul) begin
            op_lat = MUL_LAT;
            op_sel = SEL_MUL;
        end else if (is_load) begin
            op_lat = LOAD_LAT;
            op_sel = SEL_LOAD;
        end

        hazard = sb[rd] || (uses_rs && (sb[rs1] || sb[rs2]));

        // The entry in slot L+1 shifts into slot L on the next edge, exactly where
        // this op would land; with L == MAX_LAT no such entry can exist.
        slot_conflict = 1'b0;
        for (int k = 2; k <= MAX_LAT; k++) begin
            if (k == op_lat + 1) slot_conflict = res_v[k];
        end

        stall  = in_valid && supported && (hazard || slot_conflict);
        accept = in_valid && supported && !stall && !rst;

        issue_add  = accept && (op_add || op_sub);
        issue_sub  = accept && op_sub;
        issue_mul  = accept && op_mul;
        issue_load = accept && is_load;
        illegal    = in_valid && is_opfp && !(op_add || op_sub || op_mul) && !rst;
    end

    // Next state of the writeback slots and the scoreboard
    always_comb begin
        for (int k = 1; k < MAX_LAT; k++) begin
            nxt_v[k]   = res_v[k+1];
            nxt_rd[k]  = res_rd[k+1];
            nxt_sel[k] = res_sel[k+1];
        end
        nxt_v[MAX_LAT]   = 1'b0;
        nxt_rd[MAX_LAT]  = 5'd0;
        nxt_sel[MAX_LAT] = 2'b00;
        if (accept) begin
            for (int k = 1; k <= MAX_LAT; k++) begin
                if (k == op_lat) begin
                    nxt_v[k]   = 1'b1;
                    nxt_rd[k]  = rd;
                    nxt_sel[k] = op_sel;
                end
            end
        end

        // Clear first so a same-edge set would win.
        sb_nxt = sb;
        if (res_v[1]) sb_nxt[res_rd[1]] = 1'b0;
        if (accept)   sb_nxt[rd]        = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= 32'd0;
            for (int k = 1; k <= MAX_LAT; k++) begin
                res_v[k]   <= 1'b0;
                res_rd[k]  <= 5'd0;
                res_sel[k] <= 2'b00;
            end
        end else begin
            sb <= sb_nxt;
            for (int k = 1; k <= MAX_LAT; k++) begin
                res_v[k]   <= nxt_v[k];
                res_rd[k]  <= nxt_rd[k];
                res_sel[k] <= nxt_sel[k];
            end
        end
    end

    assign wb_valid = res_v[1];
    assign wb_rd    = res_rd[1];
    assign wb_sel   = res_sel[1];
    assign busy     = |sb;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: a pending-writeback list model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_fpu_issue_ctrl;

    localparam logic [6:0] OPFP   = 7'b1010011;
    localparam logic [6:0] LOADFP = 7'b0000111;
    localparam logic [6:0] OPINT  = 7'b0110011;
    localparam logic [4:0] F_ADD  = 5'd0;
    localparam logic [4:0] F_SUB  = 5'd1;
    localparam logic [4:0] F_MUL  = 5'd2;
    localparam int ADD_LAT = 3;
    localparam int MUL_LAT = 4;
    localparam int LOAD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [4:0] funct5 = 5'd0;
    logic [4:0] rd = 5'd0;
    logic [4:0] rs1 = 5'd0;
    logic [4:0] rs2 = 5'd0;
    logic       stall, issue_add, issue_sub, issue_mul, issue_load, illegal;
    logic       wb_valid, busy;
    logic [4:0] wb_rd;
    logic [1:0] wb_sel;

    fpu_issue_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .LOAD_LAT(LOAD_LAT), .MAX_LAT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct5(funct5),
        .rd(rd), .rs1(rs1), .rs2(rs2), .stall(stall), .issue_add(issue_add),
        .issue_sub(issue_sub), .issue_mul(issue_mul), .issue_load(issue_load),
        .illegal(illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel), .busy(busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // model: list of results still owed to the register file
    typedef struct {
        int         due;
        logic [4:0] rd;
        logic [1:0] sel;
    } wb_t;
    wb_t pend_q[$];
    int         wb_count = 0;
    int         last_wb_cyc[32];
    logic [1:0] last_wb_sel[32];

    function automatic bit reg_pending(input logic [4:0] r);
        foreach (pend_q[i]) if (pend_q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit port_booked(input int t);
        foreach (pend_q[i]) if (pend_q[i].due == t) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin : compare
        bit         sup, is_add, is_sub, is_mul, is_ld, is_ill, e_stall, e_acc, e_wb;
        int         lat;
        logic [1:0] sel;
        logic [4:0] e_rd;
        logic [1:0] e_sel;
        if (wb_valid) begin
            wb_count++;
            last_wb_cyc[wb_rd] = cyc;
            last_wb_sel[wb_rd] = wb_sel;
        end
        if (rst) begin
            pend_q.delete();
            chk("rst_stall", stall, 0);
            chk("rst_issue", {issue_add, issue_sub, issue_mul, issue_load}, 0);
            chk("rst_illegal", illegal, 0);
            chk("rst_wb", {wb_valid, wb_rd, wb_sel}, 0);
            chk("rst_busy", busy, 0);
        end else begin
            is_add = in_valid && opcode == OPFP && funct5 == F_ADD;
            is_sub = in_valid && opcode == OPFP && funct5 == F_SUB;
            is_mul = in_valid && opcode == OPFP && funct5 == F_MUL;
            is_ld  = in_valid && opcode == LOADFP;
            is_ill = in_valid && opcode == OPFP && !(is_add || is_sub || is_mul);
            sup    = is_add || is_sub || is_mul || is_ld;
            lat    = is_mul ? MUL_LAT : (is_ld ? LOAD_LAT : ADD_LAT);
            sel    = is_mul ? 2'b01 : (is_ld ? 2'b10 : 2'b00);
            e_stall = sup && (reg_pending(rd) || port_booked(cyc + lat) ||
                              (!is_ld && (reg_pending(rs1) || reg_pending(rs2))));
            e_acc  = sup && !e_stall;
            e_wb   = 1'b0;
            e_rd   = 5'd0;
            e_sel  = 2'b00;
            foreach (pend_q[i]) begin
                if (pend_q[i].due == cyc) begin
                    e_wb  = 1'b1;
                    e_rd  = pend_q[i].rd;
                    e_sel = pend_q[i].sel;
                end
            end
            chk("stall", stall, e_stall);
            chk("issue_add", issue_add, e_acc && (is_add || is_sub));
            chk("issue_sub", issue_sub, e_acc && is_sub);
            chk("issue_mul", issue_mul, e_acc && is_mul);
            chk("issue_load", issue_load, e_acc && is_ld);
            chk("illegal", illegal, is_ill);
            chk("wb_valid", wb_valid, e_wb);
            chk("wb_rd", wb_rd, e_rd);
            chk("wb_sel", wb_sel, e_sel);
            chk("busy", busy, pend_q.size() != 0);
            for (int i = pend_q.size() - 1; i >= 0; i--) begin
                if (pend_q[i].due == cyc) pend_q.delete(i);
            end
            if (e_acc) pend_q.push_back('{due: cyc + lat, rd: rd, sel: sel});
        end
    end

    // driver tasks; each returns at the negedge of the last cycle it drove
    task automatic drive_cycle(input logic v, input logic [6:0] op, input logic [4:0] f5,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        @(posedge clk);
        #1;
        in_valid = v; opcode = op; funct5 = f5; rd = d; rs1 = s1; rs2 = s2;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic present(input logic [6:0] op, input logic [4:0] f5, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           output int icyc, output int nstall);
        icyc = -1;
        nstall = 0;
        drive_cycle(1'b1, op, f5, d, s1, s2);
        for (int i = 0; i < 20; i++) begin
            if (!stall) begin
                icyc = cyc;
                break;
            end
            nstall++;
            @(posedge clk);
            @(negedge clk);
        end
        if (icyc < 0) chk("present_timeout", 1, 0);
    endtask

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : stimulus
        int t0, ic, ns, wbc0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_wb_valid", wb_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // add rd=3: retire three cycles later, scoreboard clear the cycle after
        present(OPFP, F_ADD, 5'd3, 5'd1, 5'd2, t0, ns);
        chk("t1_nostall", ns, 0);
        chk("t1_issue_add", issue_add, 1);
        chk("t1_issue_sub", issue_sub, 0);
        idle(3);
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_rd", wb_rd, 3);
        chk("t1_wb_sel", wb_sel, 0);
        chk("t1_busy_retire", busy, 1);
        idle(1);
        chk("t1_busy_clear", busy, 0);
        idle(4);

        // mul then add colliding on the write port
        present(OPFP, F_MUL, 5'd5, 5'd8, 5'd9, t0, ns);
        present(OPFP, F_ADD, 5'd6, 5'd10, 5'd11, ic, ns);
        chk("t2_issue_cyc", ic, t0 + 2);
        chk("t2_stalls", ns, 1);
        idle(2);
        chk("t2_wb_mul", {wb_valid, wb_rd, wb_sel}, {1'b1, 5'd5, 2'b01});
        idle(1);
        chk("t2_wb_add", {wb_valid, wb_rd, wb_sel}, {1'b1, 5'd6, 2'b00});
        idle(4);

        // RAW on a mul result, no bypass on the retire cycle
        present(OPFP, F_MUL, 5'd4, 5'd16, 5'd17, t0, ns);
        present(OPFP, F_SUB, 5'd12, 5'd4, 5'd13, ic, ns);
        chk("t3_issue_cyc", ic, t0 + 5);
        chk("t3_stalls", ns, 4);
        chk("t3_issue_add", issue_add, 1);
        chk("t3_issue_sub", issue_sub, 1);
        chk("t3_mul_wb_cyc", last_wb_cyc[4], t0 + 4);
        idle(6);

        // WAW between a load and a mul
        present(LOADFP, 5'd0, 5'd7, 5'd12, 5'd12, t0, ns);
        chk("t4_load_issue", issue_load, 1);
        present(OPFP, F_MUL, 5'd7, 5'd14, 5'd15, ic, ns);
        chk("t4_issue_cyc", ic, t0 + 3);
        chk("t4_stalls", ns, 2);
        chk("t4_load_wb_cyc", last_wb_cyc[7], t0 + 2);
        chk("t4_load_wb_sel", last_wb_sel[7], 2);
        idle(4);
        chk("t4_wb_mul", {wb_valid, wb_rd, wb_sel}, {1'b1, 5'd7, 2'b01});
        idle(3);

        // illegal OPFP and a non-FP opcode
        drive_cycle(1'b1, OPFP, 5'd3, 5'd1, 5'd2, 5'd3);
        chk("t5_illegal", illegal, 1);
        chk("t5_stall", stall, 0);
        chk("t5_no_issue", {issue_add, issue_sub, issue_mul, issue_load}, 0);
        drive_cycle(1'b1, OPINT, 5'd0, 5'd1, 5'd2, 5'd3);
        chk("t5_int_outputs", {stall, issue_add, issue_sub, issue_mul, issue_load, illegal,
                               wb_valid, wb_rd, wb_sel, busy}, 0);

        // back-to-back independent adds
        present(OPFP, F_ADD, 5'd1, 5'd8, 5'd9, t0, ns);
        for (int i = 1; i < 4; i++) begin
            present(OPFP, F_ADD, 5'(i + 1), 5'd8, 5'd9, ic, ns);
            chk("t6_b2b_cyc", ic, t0 + i);
        end
        idle(6);

        // reset while add and mul are in flight
        present(OPFP, F_ADD, 5'd20, 5'd21, 5'd22, t0, ns);
        present(OPFP, F_MUL, 5'd23, 5'd24, 5'd25, ic, ns);
        chk("t7_mul_cyc", ic, t0 + 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t7_busy_rst", busy, 0);
        wbc0 = wb_count;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        present(OPFP, F_ADD, 5'd20, 5'd23, 5'd21, ic, ns);
        chk("t7_new_add_cyc", ic, t0 + 4);
        chk("t7_new_add_nostall", ns, 0);
        idle(6);
        chk("t7_wb_count", wb_count - wbc0, 1);
        chk("t7_wb_cyc", last_wb_cyc[20], t0 + 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
